// File: rtl/fifo_reuse_ctrl.sv
// Line-buffer FIFO sequencer: writes one row of L words once, then reads it
// back R times with a one-cycle read-pointer clear between passes.
module fifo_reuse_ctrl #(
   parameter int FIFO_SIZE = 4608,
   parameter int LEN_W     = $clog2(FIFO_SIZE + 1),
   parameter int REP_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] wr_len,
   input  logic [REP_W-1:0] rd_repeat,
   input  logic             in_valid,
   output logic             wr_clr,
   output logic             wr_en,
   output logic             wr_inc,
   output logic             rd_clr,
   output logic             rd_en,
   output logic             rd_inc,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_RCLR  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FIFO_SIZE);

   state_t           state_r, state_nxt_s;
   logic [LEN_W-1:0] len_r, len_nxt_s;
   logic [LEN_W-1:0] word_cnt_r, word_cnt_nxt_s;
   logic [REP_W-1:0] rep_r, rep_nxt_s;
   logic [REP_W-1:0] pass_cnt_r, pass_cnt_nxt_s;
   logic [LEN_W-1:0] len_clamp_s;
   logic             last_word_s;
   logic             last_pass_s;
   logic             out_valid_r;

   // Row length clamp and end-of-row / end-of-reuse detection
   always_comb begin
      if (wr_len > MAX_LEN) begin
         len_clamp_s = MAX_LEN;
      end else begin
         len_clamp_s = wr_len;
      end
      last_word_s = (word_cnt_r == (len_r - LEN_W'(1)));
      last_pass_s = ((pass_cnt_r + REP_W'(1)) == rep_r);
   end

   // Next-state and counter update logic
   always_comb begin
      state_nxt_s    = state_r;
      len_nxt_s      = len_r;
      rep_nxt_s      = rep_r;
      word_cnt_nxt_s = word_cnt_r;
      pass_cnt_nxt_s = pass_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               len_nxt_s = len_clamp_s;
               rep_nxt_s = rd_repeat;
               if ((len_clamp_s == LEN_W'(0)) || (rd_repeat == REP_W'(0))) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_CLR;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CLR: begin
            word_cnt_nxt_s = LEN_W'(0);
            pass_cnt_nxt_s = REP_W'(0);
            state_nxt_s    = ST_WRITE;
         end
         ST_WRITE: begin
            if (in_valid) begin
               if (last_word_s) begin
                  word_cnt_nxt_s = LEN_W'(0);
                  state_nxt_s    = ST_READ;
               end else begin
                  word_cnt_nxt_s = word_cnt_r + LEN_W'(1);
               end
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         ST_READ: begin
            if (last_word_s) begin
               word_cnt_nxt_s = LEN_W'(0);
               pass_cnt_nxt_s = pass_cnt_r + REP_W'(1);
               if (last_pass_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RCLR;
               end
            end else begin
               word_cnt_nxt_s = word_cnt_r + LEN_W'(1);
            end
         end
         ST_RCLR: state_nxt_s = ST_READ;
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, latched row parameters and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         len_r      <= LEN_W'(0);
         rep_r      <= REP_W'(0);
         word_cnt_r <= LEN_W'(0);
         pass_cnt_r <= REP_W'(0);
      end else begin
         state_r    <= state_nxt_s;
         len_r      <= len_nxt_s;
         rep_r      <= rep_nxt_s;
         word_cnt_r <= word_cnt_nxt_s;
         pass_cnt_r <= pass_cnt_nxt_s;
      end
   end

   // out_valid tracks the FIFO's registered read data: rd_en one cycle late
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= (state_r == ST_READ);
      end
   end

   // FIFO control decode; wr_en alone passes in_valid straight through
   always_comb begin
      wr_clr = 1'b0;
      wr_en  = 1'b0;
      wr_inc = 1'b0;
      rd_clr = 1'b0;
      rd_en  = 1'b0;
      rd_inc = 1'b0;
      busy   = 1'b1;
      done   = 1'b0;
      case (state_r)
         ST_IDLE:  busy = 1'b0;
         ST_CLR: begin
            wr_clr = 1'b1;
            rd_clr = 1'b1;
         end
         ST_WRITE: begin
            wr_en  = in_valid;
            wr_inc = 1'b1;
         end
         ST_READ: begin
            rd_en  = 1'b1;
            rd_inc = 1'b1;
         end
         ST_RCLR:  rd_clr = 1'b1;
         ST_DONE:  done   = 1'b1;
         default:  busy   = 1'b0;
      endcase
   end

   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fifo_reuse_ctrl.sv
// Bench for fifo_reuse_ctrl: phase-level cycle model, a stand-in FIFO for
// data-order checks, a vector table, random runs and abort/restart sequences.
module tb_fifo_reuse_ctrl;

   localparam int FS = 16;
   localparam int LW = 5;
   localparam int RW = 8;

   // {wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc, out_valid, busy, done}
   localparam logic [8:0] V_IDLE  = 9'b000000000;
   localparam logic [8:0] V_CLR   = 9'b100100010;
   localparam logic [8:0] V_RCLR  = 9'b000100110;
   localparam logic [8:0] V_DONE  = 9'b000000111;
   localparam logic [8:0] V_DONE0 = 9'b000000011;

   logic          clk;
   logic          rst;
   logic          start;
   logic [LW-1:0] wr_len;
   logic [RW-1:0] rd_repeat;
   logic          in_valid;
   logic          wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc;
   logic          out_valid, busy, done;
   logic [8:0]    obs;

   int n_cmp = 0;
   int n_err = 0;

   fifo_reuse_ctrl #(.FIFO_SIZE(FS), .LEN_W(LW), .REP_W(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .wr_len(wr_len),
      .rd_repeat(rd_repeat), .in_valid(in_valid),
      .wr_clr(wr_clr), .wr_en(wr_en), .wr_inc(wr_inc),
      .rd_clr(rd_clr), .rd_en(rd_en), .rd_inc(rd_inc),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   assign obs = {wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc, out_valid, busy, done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in FIFO driven by the controller, used to check read-back order
   logic [7:0] din;
   logic [7:0] fmem [0:31];
   logic [7:0] fdout;
   logic [4:0] fwp, frp;
   always @(posedge clk) begin
      if (wr_clr) fwp <= 5'd0;
      else if (wr_en && wr_inc) begin
         fmem[fwp] <= din;
         fwp       <= fwp + 5'd1;
      end
      if (rd_clr) begin
         frp   <= 5'd0;
         fdout <= 8'd0;
      end else if (rd_en && rd_inc) begin
         fdout <= fmem[frp];
         frp   <= frp + 5'd1;
      end
   end

   logic [8:0] exp_q [$];
   bit         vin_q [$];
   logic [7:0] din_q [$];
   int         eidx_q [$];

   typedef struct {
      int l; int r; int mode; int busy; int wr; int rd; int rclr;
   } vec_t;
   vec_t tbl [9];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic push_cyc(input logic [8:0] v, input bit iv, input logic [7:0] d, input int e);
      exp_q.push_back(v);
      vin_q.push_back(iv);
      din_q.push_back(d);
      eidx_q.push_back(e);
   endtask

   // Expected per-cycle trace from the phase rules: clear, fill, R passes, done
   task automatic build_model(input int l_raw, input int r, input int mode);
      int l, k, c;
      bit v;
      exp_q.delete(); vin_q.delete(); din_q.delete(); eidx_q.delete();
      l = (l_raw > FS) ? FS : l_raw;
      if (l == 0 || r == 0) begin
         push_cyc(V_DONE0, 1'($urandom_range(0, 1)), 8'd250, -1);
      end else begin
         push_cyc(V_CLR, 1'($urandom_range(0, 1)), 8'd251, -1);
         k = 0;
         c = 0;
         while (k < l) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (c % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            push_cyc({1'b0, v, 7'b1000010}, v,
                     v ? 8'(100 + k) : 8'(200 + $urandom_range(0, 40)), -1);
            if (v) k++;
            c++;
         end
         for (int p = 0; p < r; p++) begin
            for (int i = 0; i < l; i++)
               push_cyc({6'b000011, (i != 0), 2'b10}, 1'($urandom_range(0, 1)), 8'd252,
                        (i == 0) ? -1 : i - 1);
            if (p < r - 1) push_cyc(V_RCLR, 1'($urandom_range(0, 1)), 8'd253, l - 1);
         end
         push_cyc(V_DONE, 1'($urandom_range(0, 1)), 8'd254, l - 1);
      end
      push_cyc(V_IDLE, 1'b0, 8'd255, -1);
   endtask

   task automatic run(input int l_raw, input int r, input int mode,
                      input int abort_at, input int restart_at, input int row);
      int n_we, n_re, n_rc, n_dn, n_bz;
      n_we = 0; n_re = 0; n_rc = 0; n_dn = 0; n_bz = 0;
      build_model(l_raw, r, mode);
      wr_len    = LW'(l_raw);
      rd_repeat = RW'(r);
      in_valid  = 1'b0;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == abort_at) break;
         in_valid = vin_q[i];
         din      = din_q[i];
         if (i == restart_at) begin
            start     = 1'b1;
            wr_len    = LW'(3);
            rd_repeat = RW'(1);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         check($sformatf("trace L%0d R%0d cyc%0d", l_raw, r, i), 32'(obs), 32'(exp_q[i]));
         if (eidx_q[i] >= 0)
            check($sformatf("data L%0d R%0d cyc%0d", l_raw, r, i), 32'(fdout), 32'(100 + eidx_q[i]));
         n_we += int'(wr_en);
         n_re += int'(rd_en);
         n_rc += int'(rd_clr);
         n_dn += int'(done);
         n_bz += int'(busy);
         @(posedge clk); #1;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (row >= 0) begin
         check($sformatf("row%0d busy_cycles", row), 32'(n_bz), 32'(tbl[row].busy));
         check($sformatf("row%0d wr_en_count", row), 32'(n_we), 32'(tbl[row].wr));
         check($sformatf("row%0d rd_en_count", row), 32'(n_re), 32'(tbl[row].rd));
         check($sformatf("row%0d rd_clr_count", row), 32'(n_rc), 32'(tbl[row].rclr));
         check($sformatf("row%0d done_count", row), 32'(n_dn), 32'd1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // l, r, mode, busy, wr, rd, rclr
      tbl[0] = '{4,  1, 0, 10, 4,  4,  1};
      tbl[1] = '{3,  3, 0, 16, 3,  9,  3};
      tbl[2] = '{4,  1, 1, 13, 4,  4,  1};
      tbl[3] = '{0,  5, 0, 1,  0,  0,  0};
      tbl[4] = '{5,  0, 0, 1,  0,  0,  0};
      tbl[5] = '{20, 1, 0, 34, 16, 16, 1};
      tbl[6] = '{16, 2, 0, 51, 16, 32, 2};
      tbl[7] = '{1,  3, 0, 8,  1,  3,  3};
      tbl[8] = '{2,  1, 0, 6,  2,  2,  1};

      rst = 1'b1; start = 1'b0; wr_len = '0; rd_repeat = '0; in_valid = 1'b0; din = 8'd0;
      repeat (2) @(posedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      check("reset_outputs", 32'(obs), 32'(V_IDLE));
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 32'(obs), 32'(V_IDLE));
      @(posedge clk); #1;

      for (int t = 0; t < 8; t++)
         run(tbl[t].l, tbl[t].r, tbl[t].mode, -1, -1, t);

      // start pulse while writing must not disturb the run
      run(4, 2, 0, -1, 3, -1);

      // abort during the second read pass, then a clean restart
      run(8, 4, 0, 21, -1, -1);
      #2 rst = 1'b1;
      #1 check("abort_async_outputs", 32'(obs), 32'(V_IDLE));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("abort_hold%0d", i), 32'(obs), 32'(V_IDLE));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run(tbl[8].l, tbl[8].r, tbl[8].mode, -1, -1, 8);

      for (int n = 0; n < 20; n++)
         run(int'($urandom_range(0, 20)), int'($urandom_range(0, 4)), 2, -1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
